// File: rtl/mul_mac_pipe.sv
// mul_mac_pipe: pipelined multiplier with per-operand signedness, a clock-enable stall,
// a valid pipeline and an optional saturating accumulator with a sticky overflow flag.
// The full product is formed at the input.
// NUM_STAGE-1 delay stages then carry {valid, product, acc_en, acc_clr}.
// The final output stage either passes the product through or accumulates it.
module mul_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 16,
    parameter int SIGNED0    = 1,
    parameter int SIGNED1    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int W  = dout_WIDTH;
    // Result is treated as two's complement if either operand is signed.
    localparam bit RS = (SIGNED0 != 0) || (SIGNED1 != 0);

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] UMAX = {W{1'b1}};

    // Clamp a (W+1)-bit sum to the W-bit range; the MSB of the return value flags saturation.
    function automatic logic [W:0] sat_fn(input logic [W:0] s);
        logic [W:0] r;
        r = {1'b0, s[W-1:0]};
        if (RS) begin
            if (s[W] != s[W-1]) begin
                r = s[W] ? {1'b1, SMIN} : {1'b1, SMAX};
            end
        end else if (s[W]) begin
            r = {1'b1, UMAX};
        end
        return r;
    endfunction

    // ---- stage 0: operand extension and exact product ----
    logic signed [PW:0]  w_a;
    logic signed [PW:0]  w_b;
    logic signed [PW:0]  w_prod;
    logic signed [W-1:0] w_p;

    assign w_a    = (SIGNED0 != 0) ? (PW+1)'($signed(din0)) : (PW+1)'($unsigned(din0));
    assign w_b    = (SIGNED1 != 0) ? (PW+1)'($signed(din1)) : (PW+1)'($unsigned(din1));
    // The exact product always fits in PW+1 signed bits, so the truncated multiply is exact.
    assign w_prod = w_a * w_b;
    // An unsigned-result product has a zero MSB, so sign extension is correct for both RS cases.
    assign w_p    = W'(w_prod);

    // Index 0 is the live input beat; index g is the output of delay stage g.
    logic [NUM_STAGE-1:0] w_vld_s;
    logic [NUM_STAGE-1:0] w_en_s;
    logic [NUM_STAGE-1:0] w_clr_s;
    logic [W-1:0]         w_p_s [NUM_STAGE];

    // acc_en/acc_clr only count when the beat is valid; acc_clr needs acc_en.
    assign w_vld_s[0] = in_valid;
    assign w_en_s[0]  = in_valid & acc_en;
    assign w_clr_s[0] = in_valid & acc_en & acc_clr;
    assign w_p_s[0]   = w_p;

    // ---- stages 1..NUM_STAGE-1: delay registers ----
    for (genvar g = 1; g < NUM_STAGE; g++) begin : g_stage
        logic         r_vld_p;
        logic         r_en_p;
        logic         r_clr_p;
        logic [W-1:0] r_p_p;

        // Control bits of the beat advance on each enabled edge and are cleared by reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_p <= 1'b0;
                r_en_p  <= 1'b0;
                r_clr_p <= 1'b0;
            end else if (ce) begin
                r_vld_p <= w_vld_s[g-1];
                r_en_p  <= w_en_s[g-1];
                r_clr_p <= w_clr_s[g-1];
            end
        end

        // Product data advances with its beat; it is qualified by r_vld_p, so no reset needed.
        always_ff @(posedge clk) begin
            if (ce) begin
                r_p_p <= w_p_s[g-1];
            end
        end

        assign w_vld_s[g] = r_vld_p;
        assign w_en_s[g]  = r_en_p;
        assign w_clr_s[g] = r_clr_p;
        assign w_p_s[g]   = r_p_p;
    end

    // ---- output stage: pass-through or saturating accumulate ----
    logic         w_vld_o;
    logic         w_en_o;
    logic         w_clr_o;
    logic [W-1:0] w_p_o;
    logic [W-1:0] w_base;
    logic [W:0]   w_sum;
    logic [W:0]   w_sat;

    logic         r_out_valid;
    logic [W-1:0] r_dout;
    logic [W-1:0] r_acc;
    logic         r_ovf;

    assign w_vld_o = w_vld_s[NUM_STAGE-1];
    assign w_en_o  = w_en_s[NUM_STAGE-1];
    assign w_clr_o = w_clr_s[NUM_STAGE-1];
    assign w_p_o   = w_p_s[NUM_STAGE-1];

    assign w_base = w_clr_o ? '0 : r_acc;
    assign w_sum  = RS ? ({w_base[W-1], w_base} + {w_p_o[W-1], w_p_o})
                       : ({1'b0, w_base} + {1'b0, w_p_o});
    assign w_sat  = sat_fn(w_sum);

    // Output register: bubbles hold dout/accumulator; valid beats pass through or accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else if (ce) begin
            r_out_valid <= w_vld_o;
            if (w_vld_o) begin
                if (w_en_o) begin
                    r_acc  <= w_sat[W-1:0];
                    r_dout <= w_sat[W-1:0];
                    // A restarting beat clears the sticky flag; it cannot saturate on its own.
                    if (w_clr_o) begin
                        r_ovf <= 1'b0;
                    end else if (w_sat[W]) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_dout <= w_p_o;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_mul_mac_pipe.sv
// Directed testbench for mul_mac_pipe: default (signed x signed, 3 stages), signed x unsigned,
// unsigned x unsigned and a single-stage instance, all driven from the same stimulus.
module tb_mul_mac_pipe;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       in_valid;
    logic [5:0] din0;
    logic [5:0] din1;
    logic       acc_en;
    logic       acc_clr;

    logic        ov_a, ovf_a;
    logic [15:0] dout_a;
    logic        ov_b, ovf_b;
    logic [15:0] dout_b;
    logic        ov_c, ovf_c;
    logic [15:0] dout_c;
    logic        ov_d, ovf_d;
    logic [15:0] dout_d;

    int n_run;
    int n_fail;
    int m;
    int exp_v;

    int bub_v   [5] = '{1, 0, 1, 0, 1};
    int bub_a   [5] = '{5, 1, 7, 1, 9};
    int bub_clr [5] = '{1, 1, 0, 1, 0};
    int bub_ov  [5] = '{1, 0, 1, 0, 1};
    int bub_d   [5] = '{5, 5, 12, 12, 21};

    mul_mac_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_a), .dout(dout_a), .ovf(ovf_a)
    );

    mul_mac_pipe #(.SIGNED0(1), .SIGNED1(0)) u_su (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_b), .dout(dout_b), .ovf(ovf_b)
    );

    mul_mac_pipe #(.SIGNED0(0), .SIGNED1(0)) u_uu (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_c), .dout(dout_c), .ovf(ovf_c)
    );

    mul_mac_pipe #(.NUM_STAGE(1)) u_s1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_d), .dout(dout_d), .ovf(ovf_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [5:0] a, input logic [5:0] b,
                       input logic en, input logic clr);
        in_valid = v;
        din0     = a;
        din1     = b;
        acc_en   = en;
        acc_clr  = clr;
    endtask

    task automatic idle();
        drv(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        ce     = 1'b1;
        idle();

        // Reset state
        #1;
        chk("rst_ov", 32'(ov_a), 32'd0);
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_ov_s1", 32'(ov_d), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Pass-through: -32 * -32 = 1024, latency 3 (1 for the single-stage instance)
        drv(1'b1, 6'h20, 6'h20, 1'b0, 1'b0);
        tick();
        chk("s1_ov", 32'(ov_d), 32'd1);
        chk("s1_dout", 32'(dout_d), 32'd1024);
        idle();
        tick();
        chk("pt_ov_early", 32'(ov_a), 32'd0);
        chk("s1_ov_drop", 32'(ov_d), 32'd0);
        tick();
        chk("pt_ov", 32'(ov_a), 32'd1);
        chk("pt_dout", 32'(dout_a), 32'd1024);
        chk("pt_ovf", 32'(ovf_a), 32'd0);
        tick();
        chk("pt_ov_pulse", 32'(ov_a), 32'd0);
        chk("pt_dout_hold", 32'(dout_a), 32'd1024);

        // Signedness variants with operands 6'h3F, 6'h3F
        drv(1'b1, 6'h3F, 6'h3F, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("su_ov", 32'(ov_b), 32'd1);
        chk("su_dout", 32'(dout_b), 32'h0000FFC1);
        chk("uu_dout", 32'(dout_c), 32'd3969);
        chk("ss_dout", 32'(dout_a), 32'd1);

        // Saturation: 32 accumulated beats of 1024
        for (int n = 1; n <= 34; n++) begin
            if (n <= 32) drv(1'b1, 6'h20, 6'h20, 1'b1, (n == 1));
            else idle();
            tick();
            if (n >= 3) begin
                m = n - 2;
                exp_v = (m < 32) ? 1024 * m : 32767;
                chk($sformatf("sat_dout%0d", m), 32'(dout_a), 32'(exp_v));
                if (m >= 31) chk($sformatf("sat_ovf%0d", m), 32'(ovf_a), 32'((m == 32) ? 1 : 0));
            end
        end

        // Restart with acc_clr: 2*3 = 6, ovf cleared on arrival
        drv(1'b1, 6'd2, 6'd3, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("clr_ovf_sticky", 32'(ovf_a), 32'd1);
        tick();
        chk("clr_ov", 32'(ov_a), 32'd1);
        chk("clr_dout", 32'(dout_a), 32'd6);
        chk("clr_ovf", 32'(ovf_a), 32'd0);

        // Stall: beats 4, 9, 16 with a 5-cycle ce=0 window while beats are in flight
        drv(1'b1, 6'd2, 6'd2, 1'b0, 1'b0);
        tick();
        drv(1'b1, 6'd3, 6'd3, 1'b0, 1'b0);
        tick();
        drv(1'b1, 6'd4, 6'd4, 1'b0, 1'b0);
        tick();
        chk("stl_a_ov", 32'(ov_a), 32'd1);
        chk("stl_a_dout", 32'(dout_a), 32'd4);
        ce = 1'b0;
        drv(1'b1, 6'd7, 6'd7, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("stl_hold_ov%0d", k), 32'(ov_a), 32'd1);
            chk($sformatf("stl_hold_dout%0d", k), 32'(dout_a), 32'd4);
        end
        ce = 1'b1;
        idle();
        tick();
        chk("stl_b_ov", 32'(ov_a), 32'd1);
        chk("stl_b_dout", 32'(dout_a), 32'd9);
        tick();
        chk("stl_c_ov", 32'(ov_a), 32'd1);
        chk("stl_c_dout", 32'(dout_a), 32'd16);
        tick();
        chk("stl_end_ov", 32'(ov_a), 32'd0);
        chk("stl_end_dout", 32'(dout_a), 32'd16);
        tick();
        chk("stl_noghost", 32'(ov_a), 32'd0);

        // Bubbles interleaved with accumulated beats 5, 7, 9
        for (int n = 0; n < 7; n++) begin
            if (n < 5) drv(bub_v[n][0], 6'(bub_a[n]), 6'd1, 1'b1, bub_clr[n][0]);
            else idle();
            tick();
            if (n >= 2) begin
                chk($sformatf("bub_ov%0d", n - 2), 32'(ov_a), 32'(bub_ov[n-2]));
                chk($sformatf("bub_dout%0d", n - 2), 32'(dout_a), 32'(bub_d[n-2]));
            end
        end
        chk("bub_ovf", 32'(ovf_a), 32'd0);

        // Asynchronous reset with ovf set and two beats in flight
        for (int n = 1; n <= 34; n++) begin
            if (n <= 32) drv(1'b1, 6'h20, 6'h20, 1'b1, (n == 1));
            else drv(1'b1, 6'd2, 6'd3, 1'b1, 1'b0);
            tick();
        end
        chk("ar_pre_dout", 32'(dout_a), 32'd32767);
        chk("ar_pre_ovf", 32'(ovf_a), 32'd1);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ov", 32'(ov_a), 32'd0);
        chk("ar_dout", 32'(dout_a), 32'd0);
        chk("ar_ovf", 32'(ovf_a), 32'd0);
        chk("ar_s1_dout", 32'(dout_d), 32'd0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ar_drop%0d", k), 32'(ov_a), 32'd0);
        end
        drv(1'b1, 6'd2, 6'd3, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("ar_new_ov", 32'(ov_a), 32'd1);
        chk("ar_new_dout", 32'(dout_a), 32'd6);
        chk("ar_new_ovf", 32'(ovf_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_mac_pipe.md
Name: mul_mac_pipe

Overview:
- Parametrised pipelined multiplier with optional accumulate. Successor to the single-cycle combinational multiplier cores in the generated datapath.
- Adds a configurable pipeline depth, per-operand signedness, clock-enable stall, a valid pipeline, and a saturating accumulator with a sticky overflow flag.
- Instantiated by the datapath wherever a multiply or dot-product term needs more than one cycle.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, total latency in ce-enabled cycles; legal range >= 1.
- din0_WIDTH, 6, operand 0 width.
- din1_WIDTH, 6, operand 1 width.
- dout_WIDTH, 16, result/accumulator width; must be >= din0_WIDTH+din1_WIDTH.
- SIGNED0, 1, 1 = din0 is two's complement, 0 = unsigned.
- SIGNED1, 1, 1 = din1 is two's complement, 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ce  in  1  clock enable; 0 freezes every register.
- in_valid  in  1  din0/din1/acc_en/acc_clr carry a beat.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- acc_en  in  1  beat is accumulated rather than passed through.
- acc_clr  in  1  with acc_en: accumulator restarts at this beat.
- out_valid  out  1  dout holds a new result this cycle.
- dout  out  dout_WIDTH  product or accumulator value.
- ovf  out  1  sticky accumulator saturation flag.

Behaviour:
- Reset (asynchronous assert, any cycle including mid-pipeline): out_valid=0, dout=0, ovf=0, accumulator=0, all pipeline valid bits=0. In-flight beats are discarded. First edge after deassert behaves as a normal edge.
- Arithmetic:
  - Operand k is extended by SIGNEDk to PW+1 bits, where PW=din0_WIDTH+din1_WIDTH. P = exact product.
  - The result is signed if SIGNED0|SIGNED1, otherwise unsigned. Call this RS.
  - P is extended per RS to dout_WIDTH, so the pass-through path is always exact.
- Pipeline:
  - NUM_STAGE-1 delay registers carry {valid, P, acc_en, acc_clr}, followed by one output register. A beat sampled at ce-enabled edge k appears on dout/out_valid after edge k+NUM_STAGE-1.
  - With NUM_STAGE=1 the output register samples the inputs directly.
  - Retiming the product inside the stages is permitted; latency must not change.
- ce=0: no register changes. dout, out_valid and ovf hold their values, so a held out_valid=1 is not a new beat for consumers that qualify with ce.
- in_valid=0 beat (bubble) at the output edge: out_valid<=0; dout and accumulator hold.
- Output edge, valid beat, acc_en=0: dout<=P (extended); out_valid<=1; accumulator and ovf unchanged.
- Output edge, valid beat, acc_en=1:
  - base = acc_clr ? 0 : accumulator.
  - S = base + P, computed at dout_WIDTH+1 bits per RS.
  - If S exceeds the RS range of dout_WIDTH, it is clamped to max (signed 2^(W-1)-1, unsigned 2^W-1) or min (signed -2^(W-1), unsigned 0), and ovf<=1.
  - accumulator<=clamped S; dout<=clamped S; out_valid<=1.
- ovf:
  - Set only by saturation.
  - Cleared by reset, or by an acc_clr beat reaching the output stage. Because P alone always fits, that beat cannot saturate.
  - If a beat both clears and would set ovf, clear wins.
- acc_en/acc_clr are sampled only with in_valid=1 and travel with their beat. acc_clr with acc_en=0 is ignored.
- Back-to-back beats are accepted every ce-enabled cycle; there is no backpressure.

Test Plan:
- Defaults, pass-through: din0=-32, din1=-32, acc_en=0, single beat -> after 3 ce edges out_valid=1 for one cycle, dout=1024, ovf=0.
- SIGNED0=1, SIGNED1=0: din0=-1 (6'h3F), din1=63 -> dout=-63 (16'hFFC1). Repeat with both unsigned -> dout=3969.
- Saturation:
  - 32 consecutive beats din0=din1=-32, acc_en=1, acc_clr=1 on the first -> beats 1..31 give dout=1024*n; beat 32 gives dout=32767 and ovf=1.
  - Next beat with acc_clr=1, din0=2, din1=3 -> dout=6, ovf=0.
- Stall: issue 3 beats, hold ce=0 for 5 cycles mid-flight -> outputs frozen during stall; results emerge in order after 3 total ce-enabled edges each, none lost or duplicated.
- Bubbles: alternate in_valid 1/0 with acc_en=1, products 5,7,9 -> out_valid pattern 1,0,1,0,1; dout 5,(hold 5),12,(hold 12),21.
- Asynchronous reset pulsed mid-edge-period with 2 beats in flight and ovf=1 -> immediately out_valid=0, dout=0, ovf=0. Discarded beats never appear; the first new beat's accumulation starts from 0.
